// File: rtl/isqrt_core.sv
// Digit-by-digit integer square root: one result bit per cycle, WIDTH/2 cycles
// per operation, optional round-to-nearest with saturation on the root output.
module isqrt_core #(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     radicand_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH/2-1:0]   root_o,
  output logic [WIDTH/2:0]     rem_o,
  output logic [1:0]           dbg_state_o
);

  localparam int  HALF = WIDTH / 2;
  localparam int  CW   = $clog2(HALF + 1);
  localparam bit  RND  = (ROUND != 0);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("isqrt_core: WIDTH must be even and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [WIDTH-1:0]    r_op;
  logic [HALF-1:0]     r_root;
  logic [HALF+1:0]     r_rem;
  logic [CW-1:0]       r_cnt;
  logic [HALF-1:0]     r_root_o;
  logic [HALF:0]       r_rem_o;

  logic [HALF+1:0]     w_rem_sh;
  logic [HALF+1:0]     w_trial;
  logic                w_ge;
  logic [HALF+1:0]     w_rem_nxt;
  logic [HALF-1:0]     w_root_nxt;
  logic [HALF-1:0]     w_root_up;
  logic                w_rnd_up;
  logic                w_sat;
  logic [HALF-1:0]     w_root_fin;
  logic                w_unused;

  // The partial remainder never exceeds 2*root, so its two top bits are
  // always zero before the shift and can be dropped without loss.
  assign w_rem_sh   = {r_rem[HALF-1:0], r_op[WIDTH-1 -: 2]};
  assign w_trial    = {r_root, 2'b01};
  assign w_ge       = (w_rem_sh >= w_trial);
  assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nxt = {r_root[HALF-2:0], w_ge};

  assign w_root_up  = w_root_nxt + 1'b1;
  assign w_rnd_up   = (w_rem_nxt > {2'b00, w_root_nxt});
  assign w_sat      = &w_root_nxt;
  assign w_root_fin = (RND && w_rnd_up && !w_sat) ? w_root_up : w_root_nxt;

  assign w_unused   = ^{r_rem[HALF+1:HALF], r_root[HALF-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_op     <= '0;
      r_root   <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_root_o <= '0;
      r_rem_o  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
            r_op    <= radicand_i;
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= CW'(HALF);
          end
        end
        CALC: begin
          r_op   <= r_op << 2;
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_root_o <= w_root_fin;
            r_rem_o  <= w_rem_nxt[HALF:0];
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
            r_op    <= radicand_i;
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= CW'(HALF);
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign root_o      = r_root_o;
  assign rem_o       = r_rem_o;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_isqrt_core.sv
// Directed and sweep checks of isqrt_core in four configurations
// (16-bit floor/round, 8-bit floor/round) against an integer square-root model.
module tb_isqrt_core;

  logic        clk;
  logic        rst;
  logic        start_v [4];
  logic [15:0] rad_v   [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic [15:0] root_v  [4];
  logic [15:0] rem_v   [4];
  logic [1:0]  st_v    [4];

  logic [7:0]  root_a, root_b;
  logic [8:0]  rem_a, rem_b;
  logic [3:0]  root_c, root_d;
  logic [4:0]  rem_c, rem_d;

  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_err;

  isqrt_core #(.WIDTH(16), .ROUND(0)) u_a (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .radicand_i(rad_v[0]),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .root_o(root_a), .rem_o(rem_a),
    .dbg_state_o(st_v[0]));
  isqrt_core #(.WIDTH(16), .ROUND(1)) u_b (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .radicand_i(rad_v[1]),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .root_o(root_b), .rem_o(rem_b),
    .dbg_state_o(st_v[1]));
  isqrt_core #(.WIDTH(8), .ROUND(0)) u_c (
    .clk(clk), .rst(rst), .start_i(start_v[2]), .radicand_i(rad_v[2][7:0]),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .root_o(root_c), .rem_o(rem_c),
    .dbg_state_o(st_v[2]));
  isqrt_core #(.WIDTH(8), .ROUND(1)) u_d (
    .clk(clk), .rst(rst), .start_i(start_v[3]), .radicand_i(rad_v[3][7:0]),
    .busy_o(busy_v[3]), .done_o(done_v[3]), .root_o(root_d), .rem_o(rem_d),
    .dbg_state_o(st_v[3]));

  assign root_v[0] = {8'b0, root_a};
  assign root_v[1] = {8'b0, root_b};
  assign root_v[2] = {12'b0, root_c};
  assign root_v[3] = {12'b0, root_d};
  assign rem_v[0]  = {7'b0, rem_a};
  assign rem_v[1]  = {7'b0, rem_b};
  assign rem_v[2]  = {11'b0, rem_c};
  assign rem_v[3]  = {11'b0, rem_d};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Integer reference: {root, floor remainder}
  function automatic logic [31:0] model(input int w, input int rnd, input int x);
    int r, rem, rr;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    rem = x - r * r;
    rr  = r;
    if (rnd != 0 && rem > r) rr = ((r + 1) == (1 << (w / 2))) ? r : r + 1;
    return {rr[15:0], rem[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input int sel, output logic [31:0] e);
    check($sformatf("sb_nonempty[%0d]", sel), 32'(exp_q.size() > 0), 1);
    e = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("root[%0d]", sel), {16'b0, root_v[sel]}, {16'b0, e[31:16]});
      check($sformatf("rem[%0d]", sel), {16'b0, rem_v[sel]}, {16'b0, e[15:0]});
    end
  endtask

  // Driver: called just after a falling edge; start is seen on the next rising edge.
  task automatic op(input int sel, input int rad);
    int w, n, nb;
    logic [31:0] e;
    w = (sel < 2) ? 16 : 8;
    start_v[sel] = 1'b1;
    rad_v[sel]   = rad[15:0];
    exp_q.push_back(model(w, sel % 2, rad));
    @(negedge clk);
    start_v[sel] = 1'b0;
    rad_v[sel]   = 16'($urandom);
    n  = 1;
    nb = 0;
    while (!done_v[sel] && n < 40) begin
      if (busy_v[sel]) nb++;
      @(negedge clk);
      n++;
    end
    check($sformatf("latency[%0d] rad=%0d", sel, rad), n, w / 2 + 1);
    check($sformatf("busy_cycles[%0d]", sel), nb, w / 2);
    check_result(sel, e);
    @(negedge clk);
    check($sformatf("done_pulse[%0d]", sel), {31'b0, done_v[sel]}, 0);
    check($sformatf("root_hold[%0d]", sel), {16'b0, root_v[sel]}, {16'b0, e[31:16]});
  endtask

  initial begin
    int c, d1, d2, nd;
    logic [31:0] e;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      rad_v[i]   = '0;
    end

    // Asynchronous reset: outputs clear before any clock edge acts on it
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy[%0d]", i), {31'b0, busy_v[i]}, 0);
      check($sformatf("rst_done[%0d]", i), {31'b0, done_v[i]}, 0);
      check($sformatf("rst_root[%0d]", i), {16'b0, root_v[i]}, 0);
      check($sformatf("rst_rem[%0d]", i), {16'b0, rem_v[i]}, 0);
      check($sformatf("rst_state[%0d]", i), {30'b0, st_v[i]}, 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Floor root, 16-bit
    op(0, 144);
    @(negedge clk);
    op(0, 0);
    op(0, 65535);

    // Rounded root, 16-bit
    op(1, 15);
    op(1, 12);
    op(1, 65535);

    // start held high: back-to-back accept in DONE, ignored during CALC
    @(negedge clk);
    start_v[0] = 1'b1;
    rad_v[0]   = 16'd99;
    exp_q.push_back(model(16, 0, 99));
    @(negedge clk);
    rad_v[0] = 16'd100;
    exp_q.push_back(model(16, 0, 100));
    d1 = -1;
    d2 = -1;
    c  = 1;
    while (d2 < 0 && c < 40) begin
      if (done_v[0]) begin
        check_result(0, e);
        if (d1 < 0) d1 = c;
        else begin
          d2 = c;
          start_v[0] = 1'b0;
        end
      end
      if (d2 < 0) begin
        @(negedge clk);
        c++;
      end
    end
    start_v[0] = 1'b0;
    check("b2b_first_latency", d1, 9);
    check("b2b_spacing", d2 - d1, 9);
    @(negedge clk);
    check("b2b_idle_busy", {31'b0, busy_v[0]}, 0);
    check("b2b_idle_done", {31'b0, done_v[0]}, 0);

    // Abort in the 4th CALC cycle
    start_v[0] = 1'b1;
    rad_v[0]   = 16'd50000;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", {31'b0, busy_v[0]}, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy_v[0]}, 0);
    check("abort_done", {31'b0, done_v[0]}, 0);
    check("abort_root", {16'b0, root_v[0]}, 0);
    check("abort_rem", {16'b0, rem_v[0]}, 0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    rst = 1'b0;
    nd  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) nd++;
    end
    check("abort_no_activity", nd, 0);

    // First start accepted on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op(0, 81);

    // Random 16-bit operands, both modes
    repeat (6) begin
      op(0, int'($urandom_range(0, 65535)));
      op(1, int'($urandom_range(0, 65535)));
    end

    // Exhaustive 8-bit sweep, both modes
    for (int x = 0; x < 256; x++) begin
      op(2, x);
      op(3, x);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/isqrt_core.md
ISQRT_CORE -- requirements
Module: isqrt_core

Interface
REQ-001 Parameter: WIDTH, 16, radicand width in bits; even, >= 4.
REQ-002 Parameter: ROUND, 0, 0 = floor root, 1 = round-to-nearest root with saturation.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  request; sampled on rising edge of clk.
REQ-006 radicand_i  input  WIDTH  unsigned operand; sampled with start_i.
REQ-007 busy_o  output  1  high while iterating.
REQ-008 done_o  output  1  one-cycle pulse; root_o/rem_o valid.
REQ-009 root_o  output  WIDTH/2  result root, registered.
REQ-010 rem_o  output  WIDTH/2+1  floor remainder radicand - floor_root^2, registered.

Function
REQ-011 FSM states SHALL be IDLE, CALC, DONE; busy_o = (state==CALC); done_o = (state==DONE); both are decoded from state registers only, with no combinational path from inputs.
REQ-012 IDLE: start_i=1 -> CALC; operand, zeroed partial root/remainder and iteration counter = WIDTH/2 loaded; else stay IDLE.
REQ-013 CALC: one iteration per cycle; after exactly WIDTH/2 iterations -> DONE; start_i ignored in CALC.
REQ-014 DONE: lasts exactly one cycle; start_i=1 -> CALC (back-to-back accept, same load as REQ-012), else -> IDLE.
REQ-015 Latency: start accepted at edge E -> done_o high in the cycle after edge E+WIDTH/2; throughput one result per WIDTH/2+1 cycles.
REQ-016 Iteration (digit-by-digit, non-restoring-free): rem' = (rem<<2) | next two MSBs of operand; trial = (root<<2)|1; if rem' >= trial then rem = rem'-trial, root = (root<<1)|1, else rem = rem', root = root<<1.
REQ-017 Internal remainder SHALL be WIDTH/2+2 bits; no truncation of any intermediate value.
REQ-018 root_o/rem_o SHALL update only on the edge entering DONE and SHALL hold until the next entry to DONE.
REQ-019 ROUND=0: root_o = floor(sqrt(radicand)).
REQ-020 ROUND=1: root_o = floor_root+1 when rem > floor_root, else floor_root; if floor_root+1 would equal 2^(WIDTH/2), root_o saturates to 2^(WIDTH/2)-1.
REQ-021 rem_o SHALL always be the floor remainder, independent of ROUND; max value 2*floor_root fits WIDTH/2+1 bits.
REQ-022 radicand_i changes after acceptance SHALL NOT affect the running operation.
REQ-023 An illegal WIDTH (odd or < 4) SHALL cause an elaboration-time error.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force state=IDLE, busy_o=0, done_o=0, root_o=0, rem_o=0, all internal registers 0.
REQ-025 rst asserted mid-CALC or in DONE SHALL abort; no done_o pulse for the aborted operation; start_i is ignored while rst=1.
REQ-026 First start after rst deassertion SHALL be accepted on the first rising edge with rst=0.

Verification (WIDTH=16 unless stated)
REQ-027 ROUND=0: start with radicand 144 -> done_o high in the cycle after edge E+8, root_o=12, rem_o=0; busy_o high for exactly 8 cycles.
REQ-028 ROUND=0: radicand 0 -> root_o=0, rem_o=0; radicand 65535 -> root_o=255, rem_o=510.
REQ-029 ROUND=1: radicand 15 -> root_o=4, rem_o=6; radicand 12 -> root_o=3, rem_o=3; radicand 65535 -> root_o=255 (saturated), rem_o=510.
REQ-030 start_i held high continuously with radicands 99, 100 -> results 9/18 then 10/0, done_o pulses 9 cycles apart; start pulses during CALC ignored.
REQ-031 rst pulsed at 4th CALC cycle -> all outputs 0 asynchronously, no done_o; next start with 81 -> root_o=9, rem_o=0.
REQ-032 Exhaustive sweep WIDTH=8 both ROUND values, all 256 radicands -> root_o/rem_o match integer reference model.
